fu_wb_buffer: RTL

// - Result buffer between a long-latency functional unit (divider) and the shared writeback/bypass port.
// - The FU emits fu_output_t with a 1-cycle valid pulse and no backpressure.
// - This block queues results in a small in-order FIFO until the writeback arbiter grants.
// - A reservation counter lets the FU's issue side guarantee a free slot before starting an op.

---
 rtl/fu_wb_buffer.sv | 93 +++++++++
 1 files changed

// File: rtl/fu_wb_buffer.sv
// In-order result buffer between a long-latency FU and the shared writeback port.
// Latency: 1 cycle push->wb_o; backpressure via wb_i_ready, with issue-side slot reservation.
package fu_wb_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  id;
    logic [5:0]  prd;
    logic [63:0] rdval;
  } fu_output_t;
  localparam int FU_W = $bits(fu_output_t);
endpackage

module fu_wb_buffer
  import fu_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     reserve_i,
  output logic                     reserve_ready_o,
  input  logic [FU_W-1:0]          fuoutput_i,
  input  logic                     fuoutput_i_valid,
  output logic [FU_W-1:0]          wb_o,
  output logic                     wb_o_valid,
  input  logic                     wb_i_ready,
  input  logic                     squash_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     err_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [FU_W-1:0] mem [DEPTH];
  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   occupied, reserved;
  logic [CW-1:0]   occupied_nxt, reserved_nxt;
  logic [CW:0]     claimed;
  logic            pop, push_ok, rsv_ok, res_dec, err_set, full;

  always_comb begin
    claimed         = {1'b0, occupied} + {1'b0, reserved};
    reserve_ready_o = claimed < {1'b0, DEPTH_C};
    full            = (occupied == DEPTH_C);
    pop             = wb_o_valid && wb_i_ready;
    // A full buffer still accepts a result when the head leaves in the same cycle.
    push_ok         = fuoutput_i_valid && (!full || pop);
    rsv_ok          = reserve_i && reserve_ready_o;
    res_dec         = push_ok && (reserved != '0);
    err_set         = (reserve_i && !reserve_ready_o) ||
                      (fuoutput_i_valid && ((reserved == '0) || !push_ok));

    occupied_nxt = occupied;
    if (push_ok && !pop)      occupied_nxt = occupied + CW'(1);
    else if (!push_ok && pop) occupied_nxt = occupied - CW'(1);

    reserved_nxt = reserved;
    if (rsv_ok && !res_dec)      reserved_nxt = reserved + CW'(1);
    else if (!rsv_ok && res_dec) reserved_nxt = reserved - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      occupied <= '0;
      reserved <= '0;
      err_o    <= 1'b0;
    end else if (squash_i) begin
      // Flush drops everything in flight; err_o deliberately survives.
      head     <= '0;
      tail     <= '0;
      occupied <= '0;
      reserved <= '0;
    end else begin
      if (push_ok) tail <= tail + PW'(1);
      if (pop)     head <= head + PW'(1);
      occupied <= occupied_nxt;
      reserved <= reserved_nxt;
      if (err_set) err_o <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !squash_i && push_ok) mem[tail] <= fuoutput_i;
  end

  assign wb_o       = mem[head];
  assign wb_o_valid = (occupied != '0);
  assign count_o    = occupied;

endmodule
